// File: rtl/stream_mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module : stream_mux_arb_pkg
//  Brief  : Shared constants and helpers for the stream_mux_arb slice.
//           Mode encodings for the multiplexer and a clog2 helper that never
//           returns less than one, so that select buses are at least 1 bit.
//  Rev    : 1.0  initial release
// ============================================================================
package stream_mux_arb_pkg;

  localparam int MUX_MODE_FIXED = 0;  // channel chosen by the control input
  localparam int MUX_MODE_RR    = 1;  // channel chosen by round-robin search

  // Width of an index able to address n items; a 1-bit bus is the minimum.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : rr_arbiter
//  Brief  : Purely combinational rotate-priority search. Starting at index
//           ptr and wrapping modulo CHANNELS, grants the first requester.
//  Ports  : req          in   CHANNELS  request vector
//           ptr          in   SELW      highest-priority index this cycle
//           grant_onehot out  CHANNELS  one-hot grant (all zero if no request)
//           grant_idx    out  SELW      binary index of the grant
//           any          out  1         at least one request present
//  Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SELW     = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [CHANNELS-1:0] grant_onehot,
  output logic [SELW-1:0]     grant_idx,
  output logic                any
);

  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      // ptr is always < CHANNELS, so a single conditional subtract wraps it
      idx = int'(ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!any && req[idx]) begin
        any               = 1'b1;
        grant_idx         = SELW'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module : stream_mux_arb
//  Brief  : Registered CHANNELS-to-1 stream multiplexer with valid/ready
//           handshake. One channel is selected per cycle, either by the
//           control input (MODE=0) or by round-robin arbitration (MODE=1),
//           and its beat is captured in a one-entry output register.
//  Ports  : clock      in   1           rising-edge clock
//           reset      in   1           asynchronous active-high reset
//           in_data    in   CHANNELS*N  channel i at bits [i*N +: N]
//           in_valid   in   CHANNELS    per-channel valid
//           in_ready   out  CHANNELS    per-channel ready, at most one high
//           control    in   SELW        channel select (MODE=0 only)
//           out_data   out  N           registered selected data
//           out_valid  out  1           out_data holds an unconsumed beat
//           out_ready  in   1           consumer accept
//           out_grant  out  SELW        channel that supplied out_data
//  Rev    : 1.0  initial release
// ============================================================================
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MUX_MODE_FIXED,
  localparam int SELW     = clog2_min1(CHANNELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
  input  logic [SELW-1:0]       control,
  output logic [N-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_grant
);

  logic [CHANNELS-1:0] w_onehot;   // selected channel, one-hot
  logic [SELW-1:0]     w_sel;      // selected channel, binary
  logic                w_has_sel;  // a channel is selected this cycle
  logic                w_can_load;
  logic                w_xfer;
  logic [N-1:0]        w_sel_data;

  logic                r_out_valid;
  logic [N-1:0]        r_out_data;
  logic [SELW-1:0]     r_out_grant;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SELW-1:0] r_rr_ptr;

      rr_arbiter #(
        .CHANNELS (CHANNELS)
      ) u_arb (
        .req          (in_valid),
        .ptr          (r_rr_ptr),
        .grant_onehot (w_onehot),
        .grant_idx    (w_sel),
        .any          (w_has_sel)
      );

      // Priority moves to the channel after the one just served; it holds
      // when nothing transfers so an idle or stalled cycle costs no fairness.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_rr_ptr <= '0;
        end else if (w_xfer) begin
          r_rr_ptr <= (w_sel == SELW'(CHANNELS - 1)) ? '0 : w_sel + 1'b1;
        end
      end
    end else begin : g_fixed
      assign w_sel = control;
      // An out-of-range control value matches no channel, so nothing is
      // selected and no ready is raised.
      for (genvar i = 0; i < CHANNELS; i++) begin : g_dec
        assign w_onehot[i] = (control == SELW'(i));
      end
      assign w_has_sel = |w_onehot;
    end
  endgenerate

  assign w_can_load = !r_out_valid || out_ready;
  assign in_ready   = (w_can_load && w_has_sel && !reset) ? w_onehot : '0;
  assign w_xfer     = |(in_valid & in_ready);

  // AND-OR mux driven by the one-hot select: never indexes past the bus.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_onehot[i]) w_sel_data = w_sel_data | in_data[i*N +: N];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_grant <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_grant <= w_sel;
    end else if (out_ready) begin
      // drain without refill: data and grant keep their last values
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_grant = r_out_grant;

endmodule
`default_nettype wire
